dense_argmax: RTL and testbench

Output classification stage placed directly downstream of the `Dense` fully-connected layer. It consumes the layer's serial stream of `CLASS_COUNT` signed scores and tracks the running maximum and runner-up. It then reports the winning class index, its score and the top-1/top-2 margin, which serves as a confidence measure. The result is held until the next inference starts and is read by the host/display logic.

---
 rtl/cnn_pkg.sv | 17 +
 rtl/argmax_cmp.sv | 35 +++
 rtl/dense_argmax.sv | 131 +++++++++++++
 tb/tb_dense_argmax.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN output stage.
//   DATA_SIZE_DEF : default score width (signed two's complement)
//   SCORE_MIN     : most-negative score at the default width
//   state_t       : dense_argmax controller states
package cnn_pkg;

  localparam int unsigned DATA_SIZE_DEF = 16;

  localparam logic [DATA_SIZE_DEF-1:0] SCORE_MIN = {1'b1, {(DATA_SIZE_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FINAL   = 2'd2
  } state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Combinational top-2 update step: folds one incoming signed score s at
// position cnt into the running (max, second, idx) triple.
//   max_in/sec_in/idx_in    : current running values
//   s/cnt                   : incoming score and its class index
//   max_out/sec_out/idx_out : updated running values
// Strict signed compares, so the earliest of equal maxima keeps the index
// while a later equal score still becomes the runner-up.
module argmax_cmp #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic [DATA_SIZE-1:0] max_in,
  input  logic [DATA_SIZE-1:0] sec_in,
  input  logic [IDX_W-1:0]     idx_in,
  input  logic [DATA_SIZE-1:0] s,
  input  logic [IDX_W-1:0]     cnt,
  output logic [DATA_SIZE-1:0] max_out,
  output logic [DATA_SIZE-1:0] sec_out,
  output logic [IDX_W-1:0]     idx_out
);

  always_comb begin
    max_out = max_in;
    sec_out = sec_in;
    idx_out = idx_in;
    if ($signed(s) > $signed(max_in)) begin
      sec_out = max_in;
      max_out = s;
      idx_out = cnt;
    end else if ($signed(s) > $signed(sec_in)) begin
      sec_out = s;
    end
  end

endmodule

// File: rtl/dense_argmax.sv
// Argmax / confidence stage behind the Dense layer.
// Collects CLASS_COUNT serial signed scores after each start pulse and
// reports the winning class, its score, the top-1/top-2 margin and a tie flag.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   start    : one-cycle pulse, clears results and (re)arms collection
//   inValid  : qualifies dataIn
//   dataIn   : signed score, class order 0..CLASS_COUNT-1
//   busy     : high from the cycle after start until done
//   done     : one-cycle pulse, results valid from here until next start
//   classIdx : winning class index
//   maxScore : winning score (signed)
//   margin   : max - second (unsigned)
//   tie      : runner-up equals max
//   err      : sticky, inValid seen while not collecting
module dense_argmax
  import cnn_pkg::*;
#(
  parameter int unsigned CLASS_COUNT = 10,
  parameter int unsigned DATA_SIZE   = DATA_SIZE_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           inValid,
  input  logic [DATA_SIZE-1:0]           dataIn,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(CLASS_COUNT)-1:0] classIdx,
  output logic [DATA_SIZE-1:0]           maxScore,
  output logic [DATA_SIZE-1:0]           margin,
  output logic                           tie,
  output logic                           err
);

  localparam int unsigned IDX_W = $clog2(CLASS_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLASS_COUNT - 1);
  localparam logic [DATA_SIZE-1:0] MIN_S = {1'b1, {(DATA_SIZE-1){1'b0}}};

  state_t state, state_n;

  logic [IDX_W-1:0]     cnt;
  logic [DATA_SIZE-1:0] run_max, run_sec;
  logic [IDX_W-1:0]     run_idx;
  logic [DATA_SIZE-1:0] cmp_max, cmp_sec;
  logic [IDX_W-1:0]     cmp_idx;
  logic                 accept;

  argmax_cmp #(
    .DATA_SIZE (DATA_SIZE),
    .IDX_W     (IDX_W)
  ) u_cmp (
    .max_in  (run_max),
    .sec_in  (run_sec),
    .idx_in  (run_idx),
    .s       (dataIn),
    .cnt     (cnt),
    .max_out (cmp_max),
    .sec_out (cmp_sec),
    .idx_out (cmp_idx)
  );

  // start has priority over a coincident score
  assign accept = (state == ST_COLLECT) && inValid && !start;
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start) begin
      state_n = ST_COLLECT;
    end else begin
      unique case (state)
        ST_IDLE:    state_n = ST_IDLE;
        ST_COLLECT: if (accept && (cnt == LAST_IDX)) state_n = ST_FINAL;
        ST_FINAL:   state_n = ST_IDLE;
        default:    state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      run_max  <= MIN_S;
      run_sec  <= MIN_S;
      run_idx  <= '0;
      done     <= 1'b0;
      classIdx <= '0;
      maxScore <= '0;
      margin   <= '0;
      tie      <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        cnt      <= '0;
        run_max  <= MIN_S;
        run_sec  <= MIN_S;
        run_idx  <= '0;
        classIdx <= '0;
        maxScore <= '0;
        margin   <= '0;
        tie      <= 1'b0;
        err      <= 1'b0;
      end else begin
        if (inValid && (state != ST_COLLECT)) err <= 1'b1;
        if (accept) begin
          run_max <= cmp_max;
          run_sec <= cmp_sec;
          run_idx <= cmp_idx;
          cnt     <= cnt + 1'b1;
        end
        if (state == ST_FINAL) begin
          classIdx <= run_idx;
          maxScore <= run_max;
          // max >= second, so the DATA_SIZE+1-bit difference is non-negative
          // and its low DATA_SIZE bits equal this modular subtraction
          margin   <= run_max - run_sec;
          tie      <= (run_max == run_sec);
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dense_argmax.sv
module tb_dense_argmax;
  import cnn_pkg::*;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          inValid;
  logic [DW-1:0] dataIn;
  logic          busy, done, tie, err;
  logic [IW-1:0] classIdx;
  logic [DW-1:0] maxScore, margin;

  dense_argmax #(.CLASS_COUNT(N), .DATA_SIZE(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .inValid  (inValid),
    .dataIn   (dataIn),
    .busy     (busy),
    .done     (done),
    .classIdx (classIdx),
    .maxScore (maxScore),
    .margin   (margin),
    .tie      (tie),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic [DW-1:0] mx;
    logic [DW-1:0] mg;
    bit            tie;
    longint        cyc;
  } exp_t;

  exp_t          sbq[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  longint        cyc    = 0;
  logic [DW-1:0] sc [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: winner is the first maximal score; runner-up is the largest
  // of all remaining scores.
  function automatic exp_t model();
    exp_t e;
    int   v[N];
    int   best = 0;
    int   sec  = $signed(SCORE_MIN);
    for (int i = 0; i < N; i++) v[i] = $signed(sc[i]);
    for (int i = 1; i < N; i++) if (v[i] > v[best]) best = i;
    for (int i = 0; i < N; i++) if (i != best && v[i] > sec) sec = v[i];
    e.idx = best;
    e.mx  = DW'(v[best]);
    e.mg  = DW'(v[best] - sec);
    e.tie = (v[best] == sec);
    e.cyc = 0;
    return e;
  endfunction

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
      end else begin
        e = sbq.pop_front();
        chk("classIdx",   64'(classIdx), 64'(e.idx));
        chk("maxScore",   64'(maxScore), 64'(e.mx));
        chk("margin",     64'(margin),   64'(e.mg));
        chk("tie",        64'(tie),      64'(e.tie));
        chk("err_at_done", 64'(err),     64'd0);
        chk("busy_at_done", 64'(busy),   64'd0);
        chk("done_cycle", 64'(cyc),      64'(e.cyc));
      end
    end
  end

  task automatic cyc1(input bit st, input bit v, input logic [DW-1:0] d);
    start   = st;
    inValid = v;
    dataIn  = d;
    @(negedge clk);
  endtask

  task automatic run_scores(input int maxgap);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, maxgap)) cyc1(1'b0, 1'b0, DW'($urandom));
      if (i == N - 1) begin
        e = model();
        e.cyc = cyc + 2;
        sbq.push_back(e);
      end
      cyc1(1'b0, 1'b1, sc[i]);
    end
    start   = 1'b0;
    inValid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && sbq.size() != 0; k++) cyc1(1'b0, 1'b0, '0);
    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected %0d pending", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic infer(input int maxgap);
    cyc1(1'b1, 1'b0, '0);
    run_scores(maxgap);
    drain();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},     64'(busy),     64'd0);
    chk({tag, "_done"},     64'(done),     64'd0);
    chk({tag, "_err"},      64'(err),      64'd0);
    chk({tag, "_tie"},      64'(tie),      64'd0);
    chk({tag, "_classIdx"}, 64'(classIdx), 64'd0);
    chk({tag, "_maxScore"}, 64'(maxScore), 64'd0);
    chk({tag, "_margin"},   64'(margin),   64'd0);
  endtask

  initial begin
    exp_t keep;
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t keep;
    int   mode;
    rst = 1'b0; start = 1'b0; inValid = 1'b0; dataIn = '0;
    #12;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("post_reset");

    // ascending
    for (int i = 0; i < N; i++) sc[i] = DW'(i);
    cyc1(1'b1, 1'b0, '0);
    chk("busy_after_start", 64'(busy), 64'd1);
    run_scores(0);
    drain();

    // all negative, max -5 at index 1
    sc = '{-16'sd100, -16'sd5, -16'sd300, -16'sd7, -16'sd50,
           -16'sd1000, -16'sd6, -16'sd200, -16'sd32768, -16'sd9};
    infer(0);

    // duplicated maximum
    for (int i = 0; i < N; i++) sc[i] = '0;
    sc[3] = 16'd7; sc[8] = 16'd7;
    infer(0);

    // extremes
    for (int i = 0; i < N; i++) sc[i] = 16'h8000;
    sc[0] = 16'h7FFF;
    infer(0);

    // gaps, then stray inValid after done
    for (int i = 0; i < N; i++) sc[i] = DW'($urandom);
    infer(5);
    keep = model();
    cyc1(1'b0, 1'b1, 16'h7FFF);
    cyc1(1'b0, 1'b1, 16'h7FFF);
    cyc1(1'b0, 1'b0, '0);
    chk("stray_err",      64'(err),      64'd1);
    chk("stray_classIdx", 64'(classIdx), 64'(keep.idx));
    chk("stray_maxScore", 64'(maxScore), 64'(keep.mx));
    chk("stray_margin",   64'(margin),   64'(keep.mg));
    cyc1(1'b1, 1'b0, '0);
    chk("start_clears_err", 64'(err), 64'd0);
    for (int i = 0; i < N; i++) sc[i] = DW'($urandom);
    run_scores(0);
    drain();

    // abort after 4 scores, restart with fresh data
    cyc1(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) cyc1(1'b0, 1'b1, 16'h7FFF);
    for (int i = 0; i < N; i++) sc[i] = DW'($urandom_range(0, 1000));
    infer(0);

    // score coinciding with start is discarded
    cyc1(1'b1, 1'b1, 16'h7FFF);
    for (int i = 0; i < N; i++) sc[i] = DW'($urandom_range(0, 1000));
    run_scores(1);
    drain();

    // reset while holding a result with err set
    cyc1(1'b0, 1'b1, '0);
    cyc1(1'b0, 1'b0, '0);
    rst = 1'b0;
    #1;
    chk_zero("idle_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // reset mid-collect: no done may follow
    cyc1(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) cyc1(1'b0, 1'b1, DW'($urandom));
    rst = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (15) cyc1(1'b0, 1'b0, '0);
    chk_zero("after_mid_reset");

    // randomized inferences
    for (int t = 0; t < 25; t++) begin
      mode = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
        case (mode)
          0:       sc[i] = DW'($urandom);
          1:       sc[i] = DW'($urandom_range(0, 3));
          default: begin
            case ($urandom_range(0, 2))
              0:       sc[i] = 16'h7FFF;
              1:       sc[i] = 16'h8000;
              default: sc[i] = 16'h0000;
            endcase
          end
        endcase
      end
      infer($urandom_range(0, 2));
    end

    repeat (3) cyc1(1'b0, 1'b0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
